// File: rtl/line_clear_if.sv
// Handshake and board bus between the board datapath (master) and line_clear (slave).
interface line_clear_if;
    logic        start;
    logic [31:0] board_in;
    logic        busy;
    logic        done;
    logic [31:0] board_out;
    logic [3:0]  rows_cleared;
    logic [15:0] score;

    modport master (
        output start,
        output board_in,
        input  busy,
        input  done,
        input  board_out,
        input  rows_cleared,
        input  score
    );

    modport slave (
        input  start,
        input  board_in,
        output busy,
        output done,
        output board_out,
        output rows_cleared,
        output score
    );
endinterface

// File: rtl/line_clear.sv
// Row-clear stage: scans one row per clock, drops full rows and compacts the board downward.
// Define LINE_CLEAR_SCORE_EN to build the saturating score accumulator; otherwise score is 0.
module line_clear #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 4
) (
    input logic         clka,
    input logic         restart,
    line_clear_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] board_out_q, board_out_d;
    logic [3:0]  rd_q, rd_d;
    logic [3:0]  wr_q, wr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  rows_cleared_q, rows_cleared_d;
    logic [COLS-1:0] row;
    logic        last_row;

    // Row mux written as a compare loop so every slice index is a constant.
    always_comb begin
        row = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (rd_q == 4'(r)) begin
                row = src_q[r*COLS +: COLS];
            end
        end
    end

    assign last_row = (rd_q == 4'(ROWS - 1));

    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        dst_d          = dst_q;
        rd_d           = rd_q;
        wr_d           = wr_q;
        cnt_d          = cnt_q;
        board_out_d    = board_out_q;
        rows_cleared_d = rows_cleared_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StScan;
                    src_d   = bus.board_in;
                    dst_d   = '0;
                    rd_d    = '0;
                    wr_d    = '0;
                    cnt_d   = '0;
                end
            end
            StScan: begin
                if (&row) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    for (int unsigned r = 0; r < ROWS; r++) begin
                        if (wr_q == 4'(r)) begin
                            dst_d[r*COLS +: COLS] = row;
                        end
                    end
                    wr_d = wr_q + 4'd1;
                end
                rd_d = rd_q + 4'd1;
                // Results land on the edge that enters StDone, alongside the done pulse.
                if (last_row) begin
                    state_d        = StDone;
                    board_out_d    = dst_d;
                    rows_cleared_d = cnt_d;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state_q        <= StIdle;
            src_q          <= '0;
            dst_q          <= '0;
            rd_q           <= '0;
            wr_q           <= '0;
            cnt_q          <= '0;
            board_out_q    <= '0;
            rows_cleared_q <= '0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            dst_q          <= dst_d;
            rd_q           <= rd_d;
            wr_q           <= wr_d;
            cnt_q          <= cnt_d;
            board_out_q    <= board_out_d;
            rows_cleared_q <= rows_cleared_d;
        end
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = (state_q == StDone);
    assign bus.board_out    = board_out_q;
    assign bus.rows_cleared = rows_cleared_q;

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [15:0] weight;
    logic [16:0] sum;

    always_comb begin
        case (cnt_d)
            4'd0:    weight = 16'd0;
            4'd1:    weight = 16'd1;
            4'd2:    weight = 16'd3;
            4'd3:    weight = 16'd5;
            default: weight = 16'd8;
        endcase
        sum     = {1'b0, score_q} + {1'b0, weight};
        score_d = score_q;
        if ((state_q == StScan) && last_row) begin
            score_d = sum[16] ? 16'hFFFF : sum[15:0];
        end
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign bus.score = score_q;
`else
    assign bus.score = 16'h0000;
`endif
endmodule

// File: tb/tb_line_clear.sv
// Directed bench for line_clear: a scoreboard of expected results checked on each done pulse.
module tb_line_clear;
    localparam int ROWS = 8;

    typedef struct {
        logic [31:0] board;
        logic [3:0]  rows;
        logic [15:0] score;
    } exp_t;

    logic clka = 1'b0;
    logic restart;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   start_cyc = 0;
    logic [15:0] exp_score = 16'h0000;
    exp_t sb[$];

    always #5 clka = ~clka;

    line_clear_if bus ();

    line_clear #(
        .ROWS(8),
        .COLS(4)
    ) dut (
        .clka(clka),
        .restart(restart),
        .bus(bus)
    );

    always @(posedge clka) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: gather surviving rows in order, then pack them from the bottom.
    function automatic void model(input logic [31:0] b, output logic [31:0] o,
                                  output logic [3:0] n);
        logic [3:0] keep[$];
        logic [3:0] rw;
        o = '0;
        n = '0;
        for (int r = 0; r < ROWS; r++) begin
            rw = b[r*4 +: 4];
            if (rw == 4'hF) n = n + 4'd1;
            else keep.push_back(rw);
        end
        for (int i = 0; i < keep.size(); i++) o[i*4 +: 4] = keep[i];
    endfunction

    function automatic logic [15:0] add_score(input logic [15:0] s, input logic [3:0] n);
`ifdef LINE_CLEAR_SCORE_EN
        int w;
        int t;
        w = (n == 0) ? 0 : (n == 1) ? 1 : (n == 2) ? 3 : (n == 3) ? 5 : 8;
        t = int'(s) + w;
        return (t > 65535) ? 16'hFFFF : 16'(t);
`else
        return 16'h0000 & {s[15:4], n};
`endif
    endfunction

    function automatic exp_t expect_for(input logic [31:0] b);
        exp_t e;
        model(b, e.board, e.rows);
        exp_score = add_score(exp_score, e.rows);
        e.score = exp_score;
        return e;
    endfunction

    always @(negedge clka) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            done_cnt++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
                check("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("board_out", bus.board_out, e.board);
                check("rows_cleared", 32'(bus.rows_cleared), 32'(e.rows));
                check("score", 32'(bus.score), 32'(e.score));
            end
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 40; i++) begin
            if (done_cnt >= target) break;
            @(negedge clka);
        end
        check("done_seen", done_cnt, target);
    endtask

    task automatic run(input logic [31:0] b);
        int target;
        @(negedge clka);
        sb.push_back(expect_for(b));
        target = done_cnt + 1;
        bus.start    = 1'b1;
        bus.board_in = b;
        @(posedge clka);
        #1;
        start_cyc    = cyc;
        bus.start    = 1'b0;
        bus.board_in = $urandom;
        check("busy_rise", 32'(bus.busy), 32'd1);
        wait_done(target);
        check("latency", done_cyc - start_cyc, ROWS);
    endtask

    initial begin
        int target;
        restart      = 1'b1;
        bus.start    = 1'b1;
        bus.board_in = 32'hFFFF_FFFF;
        @(posedge clka);
        #1;
        check("restart_over_start", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        @(posedge clka);
        #1;
        restart = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_board", bus.board_out, 32'h0);
        check("rst_rows", 32'(bus.rows_cleared), 32'd0);
        check("rst_score", 32'(bus.score), 32'd0);

        run(32'h0000_001F);
        run(32'h00F0_1F02);
        run(32'hFFFF_FFFF);
        run(32'h1234_5678);
        run(32'h0F0F_F0F0);

        // Second start three cycles in must be ignored.
        @(negedge clka);
        sb.push_back(expect_for(32'h0000_F0F1));
        target       = done_cnt + 1;
        bus.start    = 1'b1;
        bus.board_in = 32'h0000_F0F1;
        @(posedge clka);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clka);
        @(negedge clka);
        bus.start    = 1'b1;
        bus.board_in = 32'hFFFF_FFFF;
        @(posedge clka);
        #1;
        bus.start = 1'b0;
        wait_done(target);
        repeat (15) @(negedge clka);
        check("single_done", done_cnt, target);

        // Restart during the 4th scan cycle aborts without a done pulse.
        @(negedge clka);
        target       = done_cnt;
        bus.start    = 1'b1;
        bus.board_in = 32'hFFFF_FFFF;
        @(posedge clka);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clka);
        @(negedge clka);
        restart = 1'b1;
        @(posedge clka);
        #1;
        restart   = 1'b0;
        exp_score = 16'h0000;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_board", bus.board_out, 32'h0);
        check("abort_score", 32'(bus.score), 32'd0);
        repeat (15) @(negedge clka);
        check("no_done_after_abort", done_cnt, target);

        run(32'h0000_001F);

`ifdef LINE_CLEAR_SCORE_EN
        @(negedge clka);
        force dut.score_q = 16'hFFFA;
        @(negedge clka);
        release dut.score_q;
        exp_score = 16'hFFFA;
`endif
        run(32'hFFFF_FFFF);
        run(32'hFFFF_FFFF);
        run(32'h00FF_0000);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
